// File: rtl/frame_buf_sched.sv
// rtl/frame_buf_sched.sv - frame-buffer scheduler between one write engine and one reader
//
// Purpose: hands the producer its next write buffer (round-robin, never the
// buffer the reader holds), grants the newest completed frame to the reader
// through a req/ack handshake, flags frames superseded unread and stretches
// each completed frame into an INTR_WIDTH-cycle interrupt.
//
// Ports:
//   I_Clk, I_Rst_n   clock; synchronous active-low reset
//   I_Wr_Done        producer finished writing O_Wr_Idx (1-cycle pulse)
//   O_Wr_Idx         buffer the producer writes next (1..BUF_NUM)
//   I_Rd_Req         reader wants a fresh frame (level, sampled in RD_IDLE)
//   O_Rd_Ack         O_Rd_Idx now valid and held by the reader (1-cycle pulse)
//   O_Rd_Idx         buffer held by the reader, 0 when none
//   I_Rd_Release     reader done with O_Rd_Idx (1-cycle pulse)
//   O_Frame_Drop     completed frame overwritten before being read
//   O_Intr           interrupt, high INTR_WIDTH cycles after the last frame
//   O_Drop_Cnt       saturating drop count (only with FRAME_BUF_SCHED_DROP_CNT_EN)
//
// Optional feature macro: FRAME_BUF_SCHED_DROP_CNT_EN

module frame_buf_sched #(
   parameter int BUF_NUM    = 3,
   parameter int INTR_WIDTH = 10
) (
   input  logic        I_Clk,
   input  logic        I_Rst_n,
   input  logic        I_Wr_Done,
   output logic [7:0]  O_Wr_Idx,
   input  logic        I_Rd_Req,
   output logic        O_Rd_Ack,
   output logic [7:0]  O_Rd_Idx,
   input  logic        I_Rd_Release,
   output logic        O_Frame_Drop,
   output logic        O_Intr
`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
   ,
   output logic [15:0] O_Drop_Cnt
`endif
);

   // A zero-width counter is illegal, so INTR_WIDTH=0 keeps one bit that stays 0.
   localparam int CNT_W = (INTR_WIDTH > 0) ? $clog2(INTR_WIDTH + 1) : 1;

   localparam logic [1:0] RD_IDLE = 2'd0;
   localparam logic [1:0] RD_WAIT = 2'd1;
   localparam logic [1:0] RD_HOLD = 2'd2;

   logic [1:0]       rd_state;
   logic [7:0]       latest;
   logic             fresh;
   logic [CNT_W-1:0] intr_cnt;
   logic [CNT_W-1:0] intr_cnt_next;

   logic             grant;
   logic             release_hit;
   logic             drop_hit;
   logic [7:0]       grant_idx;
   logic [7:0]       held_next;
   logic [7:0]       wr_next;
   logic             found;
   int               cand;

   always_comb begin
      grant = 1'b0;
      case (rd_state)
         RD_IDLE: grant = I_Rd_Req && (fresh || I_Wr_Done);
         RD_WAIT: grant = fresh || I_Wr_Done;
         default: grant = 1'b0;
      endcase
   end

   // A frame finishing in the grant cycle is newer than latest, so it wins.
   assign grant_idx   = I_Wr_Done ? O_Wr_Idx : latest;
   assign release_hit = (rd_state == RD_HOLD) && I_Rd_Release;
   assign drop_hit    = I_Wr_Done && fresh && !grant;

   // Buffer the reader will hold after this edge; the write search must avoid
   // it, which also frees a buffer released in this very cycle.
   assign held_next = grant ? grant_idx : (release_hit ? 8'd0 : O_Rd_Idx);

   // Round-robin from O_Wr_Idx+1; k stops short of a full wrap, so the
   // just-completed index is never a candidate.
   always_comb begin
      wr_next = O_Wr_Idx;
      found   = 1'b0;
      cand    = 0;
      for (int k = 1; k < BUF_NUM; k++) begin
         cand = ((int'(O_Wr_Idx) - 1 + k) % BUF_NUM) + 1;
         if (!found && (8'(cand) != held_next)) begin
            wr_next = 8'(cand);
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      intr_cnt_next = intr_cnt;
      if (I_Wr_Done) begin
         intr_cnt_next = CNT_W'(INTR_WIDTH);
      end else if (intr_cnt != '0) begin
         intr_cnt_next = intr_cnt - 1'b1;
      end
   end

   always_ff @(posedge I_Clk) begin
      if (!I_Rst_n) begin
         O_Wr_Idx     <= 8'd1;
         O_Rd_Idx     <= 8'd0;
         O_Rd_Ack     <= 1'b0;
         O_Frame_Drop <= 1'b0;
         O_Intr       <= 1'b0;
         latest       <= 8'd0;
         fresh        <= 1'b0;
         rd_state     <= RD_IDLE;
         intr_cnt     <= '0;
      end else begin
         O_Rd_Ack     <= grant;
         O_Frame_Drop <= drop_hit;
         O_Rd_Idx     <= held_next;
         intr_cnt     <= intr_cnt_next;
         // Registered copy of (counter != 0) keeps the interrupt glitch-free.
         O_Intr       <= (intr_cnt_next != '0);

         if (I_Wr_Done) begin
            latest   <= O_Wr_Idx;
            O_Wr_Idx <= wr_next;
         end

         if (grant) begin
            fresh <= 1'b0;
         end else if (I_Wr_Done) begin
            fresh <= 1'b1;
         end

         case (rd_state)
            RD_IDLE: begin
               if (grant) begin
                  rd_state <= RD_HOLD;
               end else if (I_Rd_Req) begin
                  rd_state <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (grant) begin
                  rd_state <= RD_HOLD;
               end
            end
            RD_HOLD: begin
               if (release_hit) begin
                  rd_state <= RD_IDLE;
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
   always_ff @(posedge I_Clk) begin
      if (!I_Rst_n) begin
         O_Drop_Cnt <= 16'd0;
      end else if (drop_hit && (O_Drop_Cnt != 16'hFFFF)) begin
         O_Drop_Cnt <= O_Drop_Cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_frame_buf_sched.sv
// tb/tb_frame_buf_sched.sv - scoreboard bench for frame_buf_sched (two configurations)

module tb_frame_buf_sched;

   logic clk;
   logic rst_n;
   logic wr_done;
   logic rd_req;
   logic rd_release;

   logic [7:0] wr0, rd0, wr1, rd1;
   logic       ack0, drop0, intr0, ack1, drop1, intr1;
`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
   logic [15:0] cnt0, cnt1;
`endif

   frame_buf_sched #(.BUF_NUM(3), .INTR_WIDTH(10)) dut0 (
      .I_Clk(clk), .I_Rst_n(rst_n), .I_Wr_Done(wr_done), .O_Wr_Idx(wr0),
      .I_Rd_Req(rd_req), .O_Rd_Ack(ack0), .O_Rd_Idx(rd0), .I_Rd_Release(rd_release),
      .O_Frame_Drop(drop0), .O_Intr(intr0)
`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
      , .O_Drop_Cnt(cnt0)
`endif
   );

   frame_buf_sched #(.BUF_NUM(5), .INTR_WIDTH(0)) dut1 (
      .I_Clk(clk), .I_Rst_n(rst_n), .I_Wr_Done(wr_done), .O_Wr_Idx(wr1),
      .I_Rd_Req(rd_req), .O_Rd_Ack(ack1), .O_Rd_Idx(rd1), .I_Rd_Release(rd_release),
      .O_Frame_Drop(drop1), .O_Intr(intr1)
`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
      , .O_Drop_Cnt(cnt1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int wr;
      int held;
      bit ack;
      bit drop;
      bit intr;
      int cnt;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int checks = 0;
   int errors = 0;

   // Reference model: per configuration, who holds which buffer, which frame
   // is newest, whether a reader is waiting, and when the last frame finished.
   int m_wr[2];
   int m_held[2];
   int m_latest[2];
   bit m_fresh[2];
   bit m_wait[2];
   int m_last_done[2];
   int m_cnt[2];

   function automatic int nb_of(input int k);
      return (k == 0) ? 3 : 5;
   endfunction

   function automatic int iw_of(input int k);
      return (k == 0) ? 10 : 0;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs applied at step n are seen by the DUT on the following edge;
   // the returned entry is what the outputs must show after that edge.
   task automatic model_step(input int k, input bit rstn, input bit done,
                             input bit req, input bit rel, input int n);
      exp_t x;
      bit   grant;
      int   gidx, new_held, c;
      x.ack  = 1'b0;
      x.drop = 1'b0;
      if (!rstn) begin
         m_wr[k] = 1; m_held[k] = 0; m_latest[k] = 0; m_fresh[k] = 1'b0;
         m_wait[k] = 1'b0; m_last_done[k] = -1000000; m_cnt[k] = 0;
      end else begin
         grant    = (m_held[k] == 0) && (m_wait[k] || req) && (m_fresh[k] || done);
         gidx     = done ? m_wr[k] : m_latest[k];
         new_held = grant ? gidx : ((m_held[k] != 0 && rel) ? 0 : m_held[k]);
         if (grant) m_wait[k] = 1'b0;
         else if (m_held[k] == 0 && req) m_wait[k] = 1'b1;
         x.ack = grant;
         if (done) begin
            x.drop = m_fresh[k] && !grant;
            m_latest[k] = m_wr[k];
            m_last_done[k] = n;
            c = m_wr[k] % nb_of(k) + 1;
            while (c == new_held || c == m_wr[k]) c = c % nb_of(k) + 1;
            m_wr[k] = c;
         end
         m_fresh[k] = grant ? 1'b0 : (done ? 1'b1 : m_fresh[k]);
         m_held[k]  = new_held;
         if (x.drop && m_cnt[k] < 65535) m_cnt[k]++;
      end
      x.wr   = m_wr[k];
      x.held = m_held[k];
      x.cnt  = m_cnt[k];
      x.intr = ((n + 1 - m_last_done[k]) >= 1) && ((n + 1 - m_last_done[k]) <= iw_of(k));
      if (k == 0) q0.push_back(x);
      else        q1.push_back(x);
   endtask

   int step_n = 0;

   task automatic drive(input bit r, input bit d, input bit q, input bit l);
      @(negedge clk);
      rst_n      = r;
      wr_done    = d;
      rd_req     = q;
      rd_release = l;
      model_step(0, r, d, q, l, step_n);
      model_step(1, r, d, q, l, step_n);
      step_n++;
   endtask

   // Monitor: compares whatever the DUTs present after each edge against the
   // oldest pending expectation.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) begin
            x = q0.pop_front();
            check("wr_idx0", int'(wr0), x.wr);
            check("rd_idx0", int'(rd0), x.held);
            check("rd_ack0", int'(ack0), int'(x.ack));
            check("drop0",   int'(drop0), int'(x.drop));
            check("intr0",   int'(intr0), int'(x.intr));
`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
            check("drop_cnt0", int'(cnt0), x.cnt);
`endif
         end
         if (q1.size() > 0) begin
            x = q1.pop_front();
            check("wr_idx1", int'(wr1), x.wr);
            check("rd_idx1", int'(rd1), x.held);
            check("rd_ack1", int'(ack1), int'(x.ack));
            check("drop1",   int'(drop1), int'(x.drop));
            check("intr1",   int'(intr1), int'(x.intr));
`ifdef FRAME_BUF_SCHED_DROP_CNT_EN
            check("drop_cnt1", int'(cnt1), x.cnt);
`endif
         end
      end
   end

   // Directed prologue, one entry per cycle: {rst_n, wr_done, rd_req, rd_release}
   logic [3:0] dir [$] = '{
      4'b0000, 4'b0000, 4'b0000,
      4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
      4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
      4'b1010, 4'b1000, 4'b1100, 4'b1100, 4'b1000, 4'b1001, 4'b1000,
      4'b0000, 4'b1010, 4'b1010, 4'b1000, 4'b1100, 4'b1000,
      4'b1001, 4'b1100, 4'b1010, 4'b1100, 4'b1100, 4'b1101, 4'b1000,
      4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b1100,
      4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
      4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
      4'b1000, 4'b1010, 4'b1000, 4'b0000, 4'b1000
   };

   initial begin
      logic [3:0] v;
      rst_n      = 1'b0;
      wr_done    = 1'b0;
      rd_req     = 1'b0;
      rd_release = 1'b0;
      for (int i = 0; i < dir.size(); i++) begin
         v = dir[i];
         drive(v[3], v[2], v[1], v[0]);
      end
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 149) != 0,
               $urandom_range(0, 99) < 35,
               $urandom_range(0, 99) < 40,
               $urandom_range(0, 99) < 30);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      check("queue_drained", q0.size() + q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_buf_sched.md
Name: frame_buf_sched

Overview:
- Frame-buffer scheduler for the PS-side video path; manages BUF_NUM frame buffers between one producer (DMA write engine) and one consumer (PS/display reader).
- Assigns the producer's next write buffer, grants the newest completed frame to the reader via req/ack, and never writes into a buffer the reader holds.
- Raises a fixed-width PS interrupt per completed frame and flags frames overwritten unread.

Parameters:
BUF_NUM, 3, number of frame buffers; legal 3..8; indices are 1-based (1..BUF_NUM), 0 means "none".
INTR_WIDTH, 10, O_Intr high time in clocks per completed frame; 0 disables the interrupt.

Ports:
I_Clk  in  1  clock.
I_Rst_n  in  1  reset, synchronous, active-low.
I_Wr_Done  in  1  one-cycle pulse: producer finished writing buffer O_Wr_Idx.
O_Wr_Idx  out  8  buffer the producer must write next.
I_Rd_Req  in  1  reader requests a fresh frame; level, sampled only in RD_IDLE.
O_Rd_Ack  out  1  one-cycle pulse: O_Rd_Idx is valid and now held by the reader.
O_Rd_Idx  out  8  buffer held by the reader; 0 when none is held.
I_Rd_Release  in  1  one-cycle pulse: reader is done with O_Rd_Idx.
O_Frame_Drop  out  1  one-cycle pulse: a completed frame was superseded before being read.
O_Intr  out  1  PS interrupt, high INTR_WIDTH cycles.

Behaviour:
- All outputs are registered and respond one cycle after the causing input.
- Reset values: O_Wr_Idx=1, O_Rd_Idx=0, O_Rd_Ack=0, O_Frame_Drop=0, O_Intr=0; internal latest=0, fresh=0, read FSM=RD_IDLE, interrupt counter=0.
- On I_Wr_Done: latest<=O_Wr_Idx; fresh<=1 unless consumed by a same-cycle grant.
- Next O_Wr_Idx after I_Wr_Done is chosen round-robin:
  - Search from O_Wr_Idx+1, wrapping BUF_NUM->1.
  - Skip the just-completed index.
  - Skip the index held by the reader, evaluated after any same-cycle grant or release.
  - BUF_NUM>=3 guarantees a candidate exists.
- O_Frame_Drop pulses when I_Wr_Done arrives while fresh=1 and that frame is not granted in the same cycle.
- Read FSM:
  - RD_IDLE: if I_Rd_Req and (fresh or I_Wr_Done), grant; else if I_Rd_Req, go to RD_WAIT.
  - RD_WAIT: grant on the first cycle fresh or I_Wr_Done is true.
  - Grant: O_Rd_Idx <= (I_Wr_Done ? O_Wr_Idx : latest); O_Rd_Ack=1 for one cycle; fresh<=0; go to RD_HOLD.
  - Same-cycle I_Wr_Done takes priority: the newest frame is granted and no drop is flagged.
  - RD_HOLD: I_Rd_Req is ignored. On I_Rd_Release, O_Rd_Idx<=0 and go to RD_IDLE; the released buffer is eligible in the same cycle's write selection.
  - I_Rd_Release outside RD_HOLD is ignored.
- Interrupt:
  - I_Wr_Done loads the counter with INTR_WIDTH; O_Intr = (counter!=0); counter decrements to 0.
  - Retrigger while active reloads, so O_Intr stays high INTR_WIDTH cycles after the last I_Wr_Done.
  - Counter width is clog2(INTR_WIDTH+1).
- Reset asserted mid-operation returns every register to its reset value on that edge; any held buffer is forgotten and the reader must re-request.
- I_Wr_Done on consecutive cycles is legal; each pulse is processed fully.

Optional Feature:
- Macro: FRAME_BUF_SCHED_DROP_CNT_EN.
- Defined: adds output O_Drop_Cnt [15:0], reset 0, incremented on each O_Frame_Drop pulse (same cycle), saturating at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then one I_Wr_Done -> next cycle O_Wr_Idx=2; O_Intr high exactly 10 cycles; O_Frame_Drop=0.
- I_Wr_Done, then I_Rd_Req -> O_Rd_Ack one pulse, O_Rd_Idx=1. Two more I_Wr_Done while holding -> O_Wr_Idx goes 2->3->2 (skips 1); second I_Wr_Done gives O_Frame_Drop pulse.
- I_Rd_Req from reset with no frame -> RD_WAIT, no ack. I_Wr_Done at cycle t -> O_Rd_Ack and O_Rd_Idx=1 at t+1, O_Wr_Idx=2, no drop.
- Reader holds 2, O_Wr_Idx=3, latest=1 fresh; I_Rd_Release with I_Wr_Done same cycle -> O_Rd_Idx=0, O_Wr_Idx=1 (2 released, round-robin from 4 wraps to 1), O_Frame_Drop pulse.
- Two I_Wr_Done 4 cycles apart -> O_Intr continuously high 14 cycles. With INTR_WIDTH=0 -> O_Intr never asserts.
- Reset pulsed during RD_HOLD -> all outputs at reset values the next cycle. With the macro defined, O_Drop_Cnt counts 3 after 3 drops and returns to 0 on reset.
